// File: rtl/nvdla_cmac_reg_ctrl_if.sv
// CSB-side register request/response bus for the CMAC register front-end.
// The requester drives one request per cycle, and the read response returns
// one cycle later.
interface nvdla_cmac_reg_ctrl_if #(
    parameter int OFFS_W = 12,
    parameter int DATA_W = 32
);
    logic              req_vld;
    logic              req_wr;
    logic [OFFS_W-1:0] req_offset;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_vld;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_vld, req_wr, req_offset, req_wdata,
        input  rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_offset, req_wdata,
        output rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/nvdla_cmac_reg_ctrl.sv
// CMAC register front-end. It owns S_STATUS, S_POINTER and the per-group op_en
// flops. It steers dual-register writes to the producer group, muxes read data,
// and presents the consumer group's configuration to the datapath.
module nvdla_cmac_reg_ctrl #(
    parameter int OFFS_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    nvdla_cmac_reg_ctrl_if.slave csb,
    output logic [OFFS_W-1:0] g0_offset,
    output logic [OFFS_W-1:0] g1_offset,
    output logic [DATA_W-1:0] g0_wr_data,
    output logic [DATA_W-1:0] g1_wr_data,
    output logic              g0_wr_en,
    output logic              g1_wr_en,
    input  logic [DATA_W-1:0] g0_rd_data,
    input  logic [DATA_W-1:0] g1_rd_data,
    input  logic              g0_op_en_trig,
    input  logic              g1_op_en_trig,
    output logic              g0_op_en,
    output logic              g1_op_en,
    input  logic              g0_conv_mode,
    input  logic              g1_conv_mode,
    input  logic [1:0]        g0_proc_prec,
    input  logic [1:0]        g1_proc_prec,
    input  logic              dp2reg_done,
    output logic              reg2dp_op_en,
    output logic              reg2dp_conv_mode,
    output logic [1:0]        reg2dp_proc_prec
);
    localparam logic [OFFS_W-1:0] OFF_STATUS  = OFFS_W'(12'h000);
    localparam logic [OFFS_W-1:0] OFF_POINTER = OFFS_W'(12'h004);
    localparam logic [OFFS_W-1:0] OFF_OP_EN   = OFFS_W'(12'h008);
    localparam logic [OFFS_W-1:0] OFF_MISC    = OFFS_W'(12'h00c);

    // Group status encoding: 0 idle, 1 running (the consumer), 2 pending.
    function automatic logic [1:0] grp_status(input logic op_en, input logic is_consumer);
        if (!op_en)
            return 2'd0;
        return is_consumer ? 2'd1 : 2'd2;
    endfunction

    logic              producer_q, producer_d;
    logic              consumer_q, consumer_d;
    logic [1:0]        op_en_q, op_en_d;
    logic              rsp_vld_q;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              wr_acc, rd_acc, is_dual, done_ok;
    logic [1:0]        op_set, op_clr;
    logic [DATA_W-1:0] rd_mux;

    assign wr_acc  = csb.req_vld & csb.req_wr;
    assign rd_acc  = csb.req_vld & ~csb.req_wr;
    assign is_dual = (csb.req_offset == OFF_OP_EN) | (csb.req_offset == OFF_MISC);

    // Both groups see the same offset and data. Only the producer group is
    // enabled, and only while it is not armed, so a queued layer's config
    // cannot be disturbed.
    assign g0_offset  = csb.req_offset;
    assign g1_offset  = csb.req_offset;
    assign g0_wr_data = csb.req_wdata;
    assign g1_wr_data = csb.req_wdata;
    assign g0_wr_en   = wr_acc & is_dual & ~producer_q & ~op_en_q[0];
    assign g1_wr_en   = wr_acc & is_dual &  producer_q & ~op_en_q[1];

    // A done pulse counts only when the consumer group is actually running.
    assign done_ok = dp2reg_done & op_en_q[consumer_q];
    assign op_set  = {g1_op_en_trig, g0_op_en_trig} & {2{csb.req_wdata[0]}};
    assign op_clr  = {done_ok & consumer_q, done_ok & ~consumer_q};

    // Next-state for the pointers and op_en flops; set has priority over clear.
    always_comb begin
        op_en_d    = op_set | (op_en_q & ~op_clr);
        consumer_d = consumer_q ^ done_ok;
        producer_d = producer_q;
        if (wr_acc && csb.req_offset == OFF_POINTER)
            producer_d = csb.req_wdata[0];
    end

    // Read mux, built from the current state before this cycle's updates.
    always_comb begin
        rd_mux = '0;
        case (csb.req_offset)
            OFF_STATUS: begin
                rd_mux[1:0]   = grp_status(op_en_q[0], ~consumer_q);
                rd_mux[17:16] = grp_status(op_en_q[1],  consumer_q);
            end
            OFF_POINTER: begin
                rd_mux[0]  = producer_q;
                rd_mux[16] = consumer_q;
            end
            OFF_OP_EN, OFF_MISC: rd_mux = producer_q ? g1_rd_data : g0_rd_data;
            default:             rd_mux = '0;
        endcase
        rsp_rdata_d = rd_acc ? rd_mux : rsp_rdata_q;
    end

    // State registers; reset clears everything, including an unfinished layer.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            producer_q  <= 1'b0;
            consumer_q  <= 1'b0;
            op_en_q     <= 2'b00;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            producer_q  <= producer_d;
            consumer_q  <= consumer_d;
            op_en_q     <= op_en_d;
            rsp_vld_q   <= rd_acc;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign csb.rsp_vld   = rsp_vld_q;
    assign csb.rsp_rdata = rsp_rdata_q;
    assign g0_op_en      = op_en_q[0];
    assign g1_op_en      = op_en_q[1];

    assign reg2dp_op_en     = op_en_q[consumer_q];
    assign reg2dp_conv_mode = consumer_q ? g1_conv_mode : g0_conv_mode;
    assign reg2dp_proc_prec = consumer_q ? g1_proc_prec : g0_proc_prec;
endmodule

// File: tb/tb_nvdla_cmac_reg_ctrl.sv
// Testbench for nvdla_cmac_reg_ctrl: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model of the register
// map, pointer handshake and op_en lifecycle. The two register groups are
// modelled here; each one holds a D_MISC_CFG word.
module tb_nvdla_cmac_reg_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nvdla_cmac_reg_ctrl_if csb ();

    logic [11:0] g0_offset, g1_offset;
    logic [31:0] g0_wr_data, g1_wr_data, g0_rd_data, g1_rd_data;
    logic        g0_wr_en, g1_wr_en, g0_trig, g1_trig, g0_op_en, g1_op_en;
    logic        g0_conv, g1_conv, done, r_op, r_conv;
    logic [1:0]  g0_prec, g1_prec, r_prec;

    // Group model state plus the front-end reference state.
    logic [31:0] misc [2];
    bit          m_prod, m_cons;
    bit          m_op [2];
    bit          m_rsp_vld;
    logic [31:0] m_rsp_data;

    int vectors = 0;
    int miscompares = 0;

    assign g0_rd_data = (g0_offset == 12'h00c) ? misc[0] : 32'h0;
    assign g1_rd_data = (g1_offset == 12'h00c) ? misc[1] : 32'h0;
    assign g0_conv    = misc[0][0];
    assign g1_conv    = misc[1][0];
    assign g0_prec    = misc[0][13:12];
    assign g1_prec    = misc[1][13:12];

    nvdla_cmac_reg_ctrl dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rst   (rst),
        .csb              (csb),
        .g0_offset        (g0_offset),
        .g1_offset        (g1_offset),
        .g0_wr_data       (g0_wr_data),
        .g1_wr_data       (g1_wr_data),
        .g0_wr_en         (g0_wr_en),
        .g1_wr_en         (g1_wr_en),
        .g0_rd_data       (g0_rd_data),
        .g1_rd_data       (g1_rd_data),
        .g0_op_en_trig    (g0_trig),
        .g1_op_en_trig    (g1_trig),
        .g0_op_en         (g0_op_en),
        .g1_op_en         (g1_op_en),
        .g0_conv_mode     (g0_conv),
        .g1_conv_mode     (g1_conv),
        .g0_proc_prec     (g0_prec),
        .g1_proc_prec     (g1_prec),
        .dp2reg_done      (done),
        .reg2dp_op_en     (r_op),
        .reg2dp_conv_mode (r_conv),
        .reg2dp_proc_prec (r_prec)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Status of one group as software sees it: 0 idle, 1 running, 2 pending.
    function automatic logic [31:0] m_status(input int g);
        if (!m_op[g]) return 32'd0;
        return (g == int'(m_cons)) ? 32'd1 : 32'd2;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] off);
        case (off)
            12'h000: return m_status(0) | (m_status(1) << 16);
            12'h004: return (32'(m_cons) << 16) | 32'(m_prod);
            12'h00c: return misc[m_prod];
            default: return 32'h0;
        endcase
    endfunction

    // One clock of stimulus: drive at negedge, check the combinational outputs,
    // advance the model across the posedge, then check the registered outputs.
    task automatic cycle(input bit vld, input bit wr, input logic [11:0] off,
                         input logic [31:0] wd, input bit dn,
                         input bit f0, input bit f1, input bit rs);
        bit dual, wen0, wen1, t0, t1, done_ok, set0, set1, clr0, clr1;
        @(negedge clk);
        dual = vld && wr && (off == 12'h008 || off == 12'h00c);
        wen0 = dual && !m_prod && !m_op[0];
        wen1 = dual &&  m_prod && !m_op[1];
        t0   = f0 || (wen0 && off == 12'h008);
        t1   = f1 || (wen1 && off == 12'h008);
        csb.req_vld    = vld;
        csb.req_wr     = wr;
        csb.req_offset = off;
        csb.req_wdata  = wd;
        done    = dn;
        g0_trig = t0;
        g1_trig = t1;
        rst     = rs;
        #1;
        check_eq("g0_wr_en", 32'(g0_wr_en), 32'(wen0));
        check_eq("g1_wr_en", 32'(g1_wr_en), 32'(wen1));
        check_eq("g0_offset", 32'(g0_offset), 32'(off));
        check_eq("g1_wr_data", g1_wr_data, wd);
        check_eq("reg2dp_op_en_c", 32'(r_op), 32'(m_op[m_cons]));
        check_eq("reg2dp_conv", 32'(r_conv), 32'(misc[m_cons][0]));
        check_eq("reg2dp_prec", 32'(r_prec), 32'(misc[m_cons][13:12]));
        @(posedge clk);
        #1;
        if (rs) begin
            m_prod = 0; m_cons = 0; m_op[0] = 0; m_op[1] = 0;
            m_rsp_vld = 0; m_rsp_data = 32'h0;
            misc[0] = 32'h0; misc[1] = 32'h0;
        end else begin
            m_rsp_vld = vld && !wr;
            if (m_rsp_vld) m_rsp_data = m_read(off);
            if (wen0 && off == 12'h00c) misc[0] = wd;
            if (wen1 && off == 12'h00c) misc[1] = wd;
            done_ok = dn && m_op[m_cons];
            set0 = t0 && wd[0];
            set1 = t1 && wd[0];
            clr0 = done_ok && !m_cons;
            clr1 = done_ok &&  m_cons;
            m_op[0] = set0 || (m_op[0] && !clr0);
            m_op[1] = set1 || (m_op[1] && !clr1);
            if (done_ok) m_cons = !m_cons;
            if (vld && wr && off == 12'h004) m_prod = wd[0];
        end
        #1;
        check_eq("rsp_vld", 32'(csb.rsp_vld), 32'(m_rsp_vld));
        if (m_rsp_vld || rs) check_eq("rsp_rdata", csb.rsp_rdata, m_rsp_data);
        check_eq("g0_op_en", 32'(g0_op_en), 32'(m_op[0]));
        check_eq("g1_op_en", 32'(g1_op_en), 32'(m_op[1]));
        check_eq("reg2dp_op_en", 32'(r_op), 32'(m_op[m_cons]));
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d);
        cycle(1, 1, off, d, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [11:0] off);
        cycle(1, 0, off, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic pulse_done();
        cycle(0, 0, 12'h0, 32'h0, 1, 0, 0, 0);
    endtask

    initial begin
        logic [11:0] offs [6];
        logic [11:0] off;
        bit          vld, rw, dn, f0, f1, rs;
        misc[0] = 32'h0; misc[1] = 32'h0;
        csb.req_vld = 0; csb.req_wr = 0; csb.req_offset = '0; csb.req_wdata = '0;
        done = 0; g0_trig = 0; g1_trig = 0; rst = 1;

        cycle(0, 0, 12'h0, 32'h0, 0, 0, 0, 1);
        cycle(0, 0, 12'h0, 32'h0, 0, 0, 0, 1);
        check_eq("rst_rsp_vld", 32'(csb.rsp_vld), 32'h0);
        check_eq("rst_rsp_rdata", csb.rsp_rdata, 32'h0);
        check_eq("rst_op_en", 32'({g1_op_en, g0_op_en}), 32'h0);
        rd(12'h000);
        check_eq("rd_status0", csb.rsp_rdata, 32'h0);
        check_eq("rd_lat", 32'(csb.rsp_vld), 32'h1);
        rd(12'h004);
        check_eq("rd_ptr0", csb.rsp_rdata, 32'h0);
        cycle(0, 0, 12'h0, 32'h0, 0, 0, 0, 0);
        check_eq("rsp_drop", 32'(csb.rsp_vld), 32'h0);

        // Layer on group 0.
        wr(12'h00c, 32'h1001);
        wr(12'h008, 32'h1);
        rd(12'h000);
        check_eq("g0_run_status", csb.rsp_rdata, 32'h1);
        check_eq("g0_run_op", 32'({r_op, g0_op_en}), 32'h3);
        check_eq("g0_run_cfg", 32'({r_conv, r_prec}), 32'h5);

        // Queue a layer on group 1, then finish layer 0.
        wr(12'h004, 32'h1);
        wr(12'h00c, 32'h2000);
        wr(12'h008, 32'h1);
        rd(12'h000);
        check_eq("g1_pend_status", csb.rsp_rdata, 32'h00020001);
        pulse_done();
        rd(12'h000);
        check_eq("after_done_status", csb.rsp_rdata, 32'h00010000);
        check_eq("after_done_g0", 32'(g0_op_en), 32'h0);
        check_eq("after_done_prec", 32'(r_prec), 32'h2);

        // Arm group 0 again, then try to rewrite its config while armed.
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h1);
        wr(12'h00c, 32'h5555);
        rd(12'h00c);
        check_eq("locked_misc", csb.rsp_rdata, 32'h1001);

        // Done and re-arm of the running group in the same cycle.
        cycle(1, 1, 12'h008, 32'h1, 1, 0, 1, 0);
        check_eq("set_wins", 32'(g1_op_en), 32'h1);
        rd(12'h004);
        check_eq("cons_toggled", csb.rsp_rdata, 32'h0);
        pulse_done();
        pulse_done();
        pulse_done();
        rd(12'h004);
        check_eq("idle_done", csb.rsp_rdata, 32'h0);

        // Reset in the middle of a layer, with a done pulse on the same edge.
        wr(12'h008, 32'h1);
        cycle(0, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        check_eq("midrst_outs", 32'({r_op, r_conv, r_prec, g1_op_en, g0_op_en, csb.rsp_vld}), 32'h0);
        rd(12'h004);
        check_eq("midrst_ptr", csb.rsp_rdata, 32'h0);

        // Random traffic.
        offs[0] = 12'h000; offs[1] = 12'h004; offs[2] = 12'h008;
        offs[3] = 12'h00c; offs[4] = 12'h010;
        for (int i = 0; i < 800; i++) begin
            offs[5] = 12'($urandom);
            off = offs[$urandom_range(0, 5)];
            vld = ($urandom_range(0, 9) < 7);
            rw  = $urandom_range(0, 1) == 1;
            dn  = ($urandom_range(0, 9) < 2);
            f0  = ($urandom_range(0, 19) == 0);
            f1  = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            cycle(vld, rw, off, $urandom, dn, f0, f1, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
